qmul_arbiter: RTL

QMUL_ARBITER -- requirements
Module: qmul_arbiter

---
 rtl/qmul_pkg.sv | 27 ++
 rtl/qmul_sat.sv | 38 +++
 rtl/qmul_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/qmul_pkg.sv
// Shared constants, saturation bounds and the S1 request record for the
// time-shared Q(I.F) multiplier.
package qmul_pkg;

    localparam int I_DEF   = 16;
    localparam int F_DEF   = 16;
    localparam int N_DEF   = 4;
    localparam int W_DEF   = I_DEF + F_DEF;
    localparam int IDW_DEF = $clog2(N_DEF);

    // Bounds are returned wide so callers can compare at full product width.
    function automatic logic signed [127:0] q_max(input int i, input int f);
        return (128'sd1 <<< (i + f - 1)) - 128'sd1;
    endfunction

    function automatic logic signed [127:0] q_min(input int i, input int f);
        return -(128'sd1 <<< (i + f - 1));
    endfunction

    // Field widths follow the package defaults for I, F and N.
    typedef struct packed {
        logic signed [W_DEF-1:0] a;
        logic signed [W_DEF-1:0] b;
        logic [IDW_DEF-1:0]      id;
    } s1_req_t;

endpackage

// File: rtl/qmul_sat.sv
// Combinational Q(I.F) multiply: full-width product, floor shift by F, and
// clamp to the representable range with a saturation flag.
module qmul_sat
    import qmul_pkg::*;
#(
    parameter int  I = I_DEF,
    parameter int  F = F_DEF,
    localparam int W = I + F
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] product_o,
    output logic                sat_o
);

    localparam int W2 = 2 * W;
    localparam logic signed [W2-1:0] MAX_X = W2'(q_max(I, F));
    localparam logic signed [W2-1:0] MIN_X = W2'(q_min(I, F));

    logic signed [W2-1:0] full;
    logic signed [W2-1:0] shifted;

    assign full    = a_i * b_i;
    assign shifted = full >>> F;

    always_comb begin
        product_o = shifted[W-1:0];
        sat_o     = 1'b0;
        if (shifted > MAX_X) begin
            product_o = MAX_X[W-1:0];
            sat_o     = 1'b1;
        end else if (shifted < MIN_X) begin
            product_o = MIN_X[W-1:0];
            sat_o     = 1'b1;
        end
    end

endmodule

// File: rtl/qmul_arbiter.sv
// Round-robin arbiter feeding one shared saturating multiplier through a
// two-stage elastic pipeline (S1 operands, S2 result).
module qmul_arbiter
    import qmul_pkg::*;
#(
    parameter int  I   = I_DEF,
    parameter int  F   = F_DEF,
    parameter int  N   = N_DEF,
    localparam int W   = I + F,
    localparam int IDW = $clog2(N)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N-1:0]        req_valid_i,
    input  logic [N-1:0][W-1:0] req_a_i,
    input  logic [N-1:0][W-1:0] req_b_i,
    output logic [N-1:0]        req_ready_o,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [IDW-1:0]      rsp_id_o,
    output logic [W-1:0]        rsp_product_o,
    output logic                rsp_sat_o
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           s1_valid_q, s1_valid_d;
    s1_req_t        s1_q, s1_d;
    logic           s2_valid_q, s2_valid_d;
    logic [W-1:0]   s2_prod_q, s2_prod_d;
    logic           s2_sat_q, s2_sat_d;
    logic [IDW-1:0] s2_id_q, s2_id_d;

    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic           s1_adv, s2_adv, xfer;
    logic [W-1:0]   mul_prod;
    logic           mul_sat;

    assign s2_adv = !s2_valid_q || rsp_ready_i;
    assign s1_adv = !s1_valid_q || s2_adv;
    assign xfer   = rst_ni && grant_valid && s1_adv;

    // Walk offsets from the far end so the requester closest to ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int off = N - 1; off >= 0; off--) begin
            if (req_valid_i[(int'(ptr_q) + off) % N]) begin
                grant_valid = 1'b1;
                grant_id    = IDW'((int'(ptr_q) + off) % N);
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (xfer) begin
            req_ready_o[grant_id] = 1'b1;
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        s2_prod_d  = s2_prod_q;
        s2_sat_d   = s2_sat_q;
        s2_id_d    = s2_id_q;
        if (xfer) begin
            ptr_d  = (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;
            s1_d.a = req_a_i[grant_id];
            s1_d.b = req_b_i[grant_id];
            s1_d.id = grant_id;
        end
        if (s1_adv) begin
            s1_valid_d = xfer;
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_prod_d = mul_prod;
                s2_sat_d  = mul_sat;
                s2_id_d   = s1_q.id;
            end
        end
    end

    qmul_sat #(
        .I (I),
        .F (F)
    ) u_sat (
        .a_i       (s1_q.a),
        .b_i       (s1_q.b),
        .product_o (mul_prod),
        .sat_o     (mul_sat)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_prod_q  <= '0;
            s2_sat_q   <= 1'b0;
            s2_id_q    <= '0;
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s2_prod_q  <= s2_prod_d;
            s2_sat_q   <= s2_sat_d;
            s2_id_q    <= s2_id_d;
        end
    end

    assign rsp_valid_o   = s2_valid_q;
    assign rsp_id_o      = s2_id_q;
    assign rsp_product_o = s2_prod_q;
    assign rsp_sat_o     = s2_sat_q;

endmodule
